// File: rtl/asip_pkg.sv
// rtl/asip_pkg.sv - shared op classes, condition codes, flag indices and flush FSM states
package asip_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_LT = 3'b010;
  localparam logic [2:0] COND_GT = 3'b011;
  localparam logic [2:0] COND_LE = 3'b100;
  localparam logic [2:0] COND_GE = 3'b101;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic {IDLE, FLUSH} flush_state_t;

endpackage

// File: rtl/conditionCheck.sv
// rtl/conditionCheck.sv - evaluates an instruction condition against the NZCV flags
module conditionCheck
  import asip_pkg::*;
(
  input  logic [1:0] i_op,
  input  logic [2:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_cond_ex,
  output logic       o_illegal
);

  logic w_n;
  logic w_z;
  logic w_v;
  logic w_pass;

  assign w_n = i_flags[FLG_N];
  assign w_z = i_flags[FLG_Z];
  assign w_v = i_flags[FLG_V];

  assign o_illegal = (i_op == OP_RSV) || ((i_op == OP_BR) && (i_cond[2:1] == 2'b11));

  // Unassigned condition codes never pass, whatever the op class.
  always_comb begin
    w_pass = 1'b0;
    case (i_cond)
      COND_AL: w_pass = 1'b1;
      COND_EQ: w_pass = w_z;
      COND_LT: w_pass = w_n ^ w_v;
      COND_GT: w_pass = ~w_z & ~(w_n ^ w_v);
      COND_LE: w_pass = w_z | (w_n ^ w_v);
      COND_GE: w_pass = ~(w_n ^ w_v);
      default: w_pass = 1'b0;
    endcase
  end

  assign o_cond_ex = w_pass & ~o_illegal;

endmodule

// File: rtl/cond_flag_unit.sv
// rtl/cond_flag_unit.sv - execute-stage NZCV register, control gating, branch flush and taken count
module cond_flag_unit
  import asip_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_e,
  input  logic             stall_e,
  input  logic [1:0]       op_e,
  input  logic [2:0]       cond_e,
  input  logic [3:0]       alu_flags,
  input  logic [1:0]       flag_write_e,
  input  logic             pcsrc_e,
  input  logic             regwrite_e,
  input  logic             memwrite_e,
  input  logic             cnt_clr,
  output logic             pcsrc,
  output logic             regwrite,
  output logic             memwrite,
  output logic             flush,
  output logic [3:0]       flags,
  output logic             illegal_cond,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  flush_state_t     r_state;
  flush_state_t     w_state_nxt;
  logic [FC_W-1:0]  r_flush_cnt;
  logic [FC_W-1:0]  w_flush_cnt_nxt;
  logic [3:0]       r_flags;
  logic [CNT_W-1:0] r_taken_cnt;
  logic             w_live;
  logic             w_cond_ex;
  logic             w_upd;

  conditionCheck u_cond_check (
    .i_op      (op_e),
    .i_cond    (cond_e),
    .i_flags   (r_flags),
    .o_cond_ex (w_cond_ex),
    .o_illegal (illegal_cond)
  );

  assign w_live   = valid_e & ~stall_e & (r_state == IDLE);
  assign w_upd    = w_live & w_cond_ex;
  assign pcsrc    = w_upd & pcsrc_e;
  assign regwrite = w_upd & regwrite_e;
  assign memwrite = w_upd & memwrite_e;
  assign flags    = r_flags;
  assign taken_cnt = r_taken_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= 4'b0000;
    end else if (w_upd) begin
      if (flag_write_e[1]) r_flags[3:2] <= alu_flags[3:2];
      if (flag_write_e[0]) r_flags[1:0] <= alu_flags[1:0];
    end
  end

  // The taken cycle itself flushes from IDLE; FLUSH covers the remaining cycles.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    flush           = 1'b0;
    case (r_state)
      IDLE: begin
        flush = pcsrc;
        if (pcsrc && (FLUSH_CYCLES > 1)) begin
          w_state_nxt     = FLUSH;
          w_flush_cnt_nxt = FC_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (!stall_e) begin
          if (r_flush_cnt == FC_W'(1)) begin
            w_state_nxt     = IDLE;
            w_flush_cnt_nxt = '0;
          end else begin
            w_flush_cnt_nxt = r_flush_cnt - 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_taken_cnt <= '0;
    end else if (cnt_clr) begin
      r_taken_cnt <= '0;
    end else if (pcsrc && (r_taken_cnt != '1)) begin
      r_taken_cnt <= r_taken_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cond_flag_unit.sv
// tb/tb_cond_flag_unit.sv - directed bench with a behavioural model and pinned literal expectations
module tb_cond_flag_unit;

  localparam int FC = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          valid_e = 1'b0;
  logic          stall_e = 1'b0;
  logic [1:0]    op_e = 2'b00;
  logic [2:0]    cond_e = 3'b000;
  logic [3:0]    alu_flags = 4'h0;
  logic [1:0]    flag_write_e = 2'b00;
  logic          pcsrc_e = 1'b0;
  logic          regwrite_e = 1'b0;
  logic          memwrite_e = 1'b0;
  logic          cnt_clr = 1'b0;
  logic          pcsrc;
  logic          regwrite;
  logic          memwrite;
  logic          flush;
  logic [3:0]    flags;
  logic          illegal_cond;
  logic [CW-1:0] taken_cnt;

  always #5 clk = ~clk;

  cond_flag_unit #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_e      (valid_e),
    .stall_e      (stall_e),
    .op_e         (op_e),
    .cond_e       (cond_e),
    .alu_flags    (alu_flags),
    .flag_write_e (flag_write_e),
    .pcsrc_e      (pcsrc_e),
    .regwrite_e   (regwrite_e),
    .memwrite_e   (memwrite_e),
    .cnt_clr      (cnt_clr),
    .pcsrc        (pcsrc),
    .regwrite     (regwrite),
    .memwrite     (memwrite),
    .flush        (flush),
    .flags        (flags),
    .illegal_cond (illegal_cond),
    .taken_cnt    (taken_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Model state: architectural flags, flush cycles still owed after the taken cycle, taken count.
  logic [3:0] m_flags = 4'h0;
  int         m_left  = 0;
  int         m_cnt   = 0;

  logic [6:0] pin_mask = 7'b0;
  logic [3:0] pin_val [0:6];
  string      nm [0:6] = '{"pcsrc", "regwrite", "memwrite", "flush", "flags", "illegal_cond", "taken_cnt"};

  function automatic bit cond_ok(input logic [3:0] f, input int c);
    bit n, z, v;
    n = f[3];
    z = f[2];
    v = f[0];
    case (c)
      0: return 1'b1;
      1: return z;
      2: return n != v;
      3: return !z && (n == v);
      4: return z || (n != v);
      5: return n == v;
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [3:0] act [0:6];
    logic [3:0] e_val [0:6];
    bit ill, ce, live, e_pc;
    if (!reset) begin
      m_flags = 4'h0;
      m_left  = 0;
      m_cnt   = 0;
    end
    ill  = (op_e == 2'b10 && cond_e >= 3'd6) || (op_e == 2'b11);
    ce   = !ill && cond_ok(m_flags, int'(cond_e));
    live = valid_e && !stall_e && (m_left == 0);
    e_pc = live && ce && pcsrc_e;
    e_val[0] = {3'b0, e_pc};
    e_val[1] = {3'b0, live && ce && regwrite_e};
    e_val[2] = {3'b0, live && ce && memwrite_e};
    e_val[3] = {3'b0, (m_left > 0) || e_pc};
    e_val[4] = m_flags;
    e_val[5] = {3'b0, ill};
    e_val[6] = 4'(m_cnt);
    act[0] = {3'b0, pcsrc};
    act[1] = {3'b0, regwrite};
    act[2] = {3'b0, memwrite};
    act[3] = {3'b0, flush};
    act[4] = flags;
    act[5] = {3'b0, illegal_cond};
    act[6] = taken_cnt;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (act[i] !== e_val[i]) begin
        errors++;
        $display("FAIL model_%s at %0t: got %0h expected %0h", nm[i], $time, act[i], e_val[i]);
      end
      if (pin_mask[i]) begin
        checks++;
        if (act[i] !== pin_val[i]) begin
          errors++;
          $display("FAIL pinned_%s at %0t: got %0h expected %0h", nm[i], $time, act[i], pin_val[i]);
        end
      end
    end
    if (reset) begin
      if (live && ce) begin
        if (flag_write_e[1]) m_flags[3:2] = alu_flags[3:2];
        if (flag_write_e[0]) m_flags[1:0] = alu_flags[1:0];
      end
      if (e_pc) m_left = FC - 1;
      else if (m_left > 0 && !stall_e) m_left = m_left - 1;
      if (cnt_clr) m_cnt = 0;
      else if (e_pc && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
    end
  end

  task automatic cyc(input bit v, input bit st, input logic [1:0] op, input logic [2:0] cd,
                     input logic [3:0] alu, input logic [1:0] fw, input bit pc, input bit rw,
                     input bit mw, input bit clr);
    @(posedge clk);
    #1;
    pin_mask     = 7'b0;
    valid_e      = v;
    stall_e      = st;
    op_e         = op;
    cond_e       = cd;
    alu_flags    = alu;
    flag_write_e = fw;
    pcsrc_e      = pc;
    regwrite_e   = rw;
    memwrite_e   = mw;
    cnt_clr      = clr;
  endtask

  task automatic pin(input int i, input logic [3:0] v);
    pin_mask[i] = 1'b1;
    pin_val[i]  = v;
  endtask

  logic [3:0] sweep_flags [0:4] = '{4'h0, 4'h4, 4'h8, 4'h9, 4'h5};
  logic [7:0] sweep_pass  [0:4] = '{8'h29, 8'h33, 8'h15, 8'h29, 8'h17};

  initial begin
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    pin(3, 0); pin(4, 0); pin(6, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;

    // N,Z only update on flags 0000
    cyc(1, 0, 0, 0, 4'hF, 2'b10, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 4'h4, 2'b11, 0, 0, 0, 0); pin(4, 4'hC);

    // taken EQ branch, two flush cycles, one squashed instruction
    cyc(1, 0, 2, 1, 0, 0, 1, 0, 0, 0); pin(4, 4'h4); pin(0, 1); pin(3, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); pin(1, 0); pin(3, 1); pin(6, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); pin(1, 1); pin(3, 0);

    // N=1,V=0: AL passes, GE branch not taken
    cyc(1, 0, 0, 0, 4'h8, 2'b11, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); pin(4, 4'h8); pin(1, 1);
    cyc(1, 0, 2, 5, 0, 0, 1, 0, 0, 0); pin(0, 0); pin(3, 0);

    // illegal condition, then a taken branch stretched by a 3-cycle stall
    cyc(1, 0, 2, 6, 4'hF, 2'b11, 1, 0, 0, 0); pin(5, 1); pin(0, 0);
    cyc(1, 0, 2, 0, 0, 0, 1, 0, 0, 0); pin(4, 4'h8); pin(0, 1); pin(3, 1);
    repeat (3) begin
      cyc(1, 1, 0, 0, 0, 0, 0, 1, 0, 0); pin(3, 1); pin(1, 0);
    end
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); pin(3, 1); pin(1, 0); pin(6, 2);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); pin(3, 0); pin(1, 1);

    for (int p = 0; p < 5; p++) begin
      cyc(1, 0, 0, 0, sweep_flags[p], 2'b11, 0, 0, 0, 0);
      for (int c = 0; c < 8; c++) begin
        cyc(1, 0, 2'(c % 2), 3'(c), 0, 0, 0, 1, 1, 0);
        pin(1, {3'b0, sweep_pass[p][c]});
      end
    end

    // reset dropped during FLUSH
    cyc(1, 0, 2, 0, 0, 0, 1, 0, 0, 0); pin(3, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    reset = 1'b0;
    pin(3, 0); pin(4, 0); pin(6, 0); pin(0, 0); pin(1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;

    // saturation at 4'hF, then clear wins over a taken branch
    repeat (16) begin
      cyc(1, 0, 2, 0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); pin(6, 4'hF);
    cyc(1, 0, 2, 0, 0, 0, 1, 0, 0, 1); pin(0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); pin(6, 0); pin(3, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); pin(3, 0);
    @(posedge clk);
    #1;
    pin_mask = 7'b0;
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
